// File: rtl/fifo2axi_sync.sv
// -----------------------------------------------------------------------------
// fifo2axi_sync
//   Pops memory words from a first-word-fall-through read FIFO and rebuilds
//   AXI4-Stream packets. Each packet starts with one header word, whose payload
//   becomes tuser. Data words are then paired into beats (first word = low half).
//   An odd trailing word gives a half beat with the upper half zeroed.
//
//   Optional feature macro: FIFO2AXI_ERR_CHECK_EN
//     Enables sop-based framing checks and the err pulse. When it is undefined,
//     sop is ignored and err is tied to 0.
//
// Ports
//   clk        core clock, rising edge
//   reset      asynchronous, active-low reset
//   din        FWFT head word: [127:0] payload, [143:128] strb, [144] eop,
//              [145] sop, upper bits ignored
//   din_valid  din holds a valid word
//   din_rd     pop strobe (a word is consumed when din_rd & din_valid)
//   m_tdata    AXIS data
//   m_tstrb    AXIS strobes
//   m_tuser    AXIS user bits (packet header payload)
//   m_tlast    AXIS last beat
//   m_tvalid   AXIS valid
//   m_tready   AXIS ready
//   pkt_done   pulses in the cycle the tlast beat transfers
//   err        registered one-cycle framing-error pulse
// -----------------------------------------------------------------------------
module fifo2axi_sync #(
  parameter int DATA_W = 256,
  parameter int STRB_W = 32,
  parameter int USER_W = 128,
  parameter int MEM_W  = 202
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MEM_W-1:0]  din,
  input  logic              din_valid,
  output logic              din_rd,
  output logic [DATA_W-1:0] m_tdata,
  output logic [STRB_W-1:0] m_tstrb,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              pkt_done,
  output logic              err
);

  localparam int PL_W    = DATA_W / 2;   // payload half of a beat
  localparam int HS_W    = STRB_W / 2;   // strobe half of a beat
  localparam int EOP_BIT = PL_W + HS_W;
  localparam int SOP_BIT = EOP_BIT + 1;

  typedef enum logic [1:0] {S_HDR, S_LO, S_HI} state_t;

  state_t            state;
  logic [USER_W-1:0] hdr_user;
  logic [PL_W-1:0]   lo_data;
  logic [HS_W-1:0]   lo_strb;

  logic [PL_W-1:0]   w_payload;
  logic [HS_W-1:0]   w_strb;
  logic              w_eop;
  logic              out_free;
  logic              pop;
  logic              hdr_bad;    // header slot holds a non-sop word
  logic              data_sop;   // data slot holds a sop word: abort and restart
  logic              unused_bits;

  assign w_payload = din[PL_W-1:0];
  assign w_strb    = din[PL_W +: HS_W];
  assign w_eop     = din[EOP_BIT];

`ifdef FIFO2AXI_ERR_CHECK_EN
  logic err_q;
  assign hdr_bad     = (state == S_HDR) && !din[SOP_BIT];
  assign data_sop    = (state != S_HDR) &&  din[SOP_BIT];
  assign err         = err_q;
  assign unused_bits = ^din[MEM_W-1:SOP_BIT+1];
`else
  assign hdr_bad     = 1'b0;
  assign data_sop    = 1'b0;
  assign err         = 1'b0;
  assign unused_bits = ^din[MEM_W-1:SOP_BIT];
`endif

  // The output register can take a new beat when it is empty or draining now.
  assign out_free = !m_tvalid || m_tready;

  // Header and non-final LO words never load a beat, so they may pop while a
  // previous beat is still stalled. tuser was copied into the output register
  // when that beat loaded.
  assign din_rd = din_valid &&
                  ((state == S_HDR) || ((state == S_LO) && !w_eop) || out_free);
  assign pop    = din_rd;

  assign pkt_done = m_tvalid && m_tready && m_tlast;

  // NOTE: every register here uses non-blocking assignments, so all reads in a
  // cycle see the pre-edge values, and a later assignment overrides an earlier one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_HDR;
      hdr_user <= '0;
      lo_data  <= '0;
      lo_strb  <= '0;
      m_tdata  <= '0;
      m_tstrb  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
`ifdef FIFO2AXI_ERR_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
`ifdef FIFO2AXI_ERR_CHECK_EN
      err_q <= pop && (hdr_bad || data_sop);
`endif
      // Drain on transfer. A load below overrides this for back-to-back beats.
      if (m_tready) m_tvalid <= 1'b0;

      if (pop) begin
        if (data_sop) begin
          // Abort the partial packet. This word is the next header.
          hdr_user <= din[USER_W-1:0];
          state    <= S_LO;
        end else begin
          case (state)
            S_HDR: begin
              if (!hdr_bad) begin
                hdr_user <= din[USER_W-1:0];
                state    <= S_LO;
              end
            end
            S_LO: begin
              if (w_eop) begin
                m_tdata  <= {{PL_W{1'b0}}, w_payload};
                m_tstrb  <= {{HS_W{1'b0}}, w_strb};
                m_tuser  <= hdr_user;
                m_tlast  <= 1'b1;
                m_tvalid <= 1'b1;
                state    <= S_HDR;
              end else begin
                lo_data <= w_payload;
                lo_strb <= w_strb;
                state   <= S_HI;
              end
            end
            S_HI: begin
              m_tdata  <= {w_payload, lo_data};
              m_tstrb  <= {w_strb, lo_strb};
              m_tuser  <= hdr_user;
              m_tlast  <= w_eop;
              m_tvalid <= 1'b1;
              state    <= w_eop ? S_HDR : S_LO;
            end
            default: state <= S_HDR;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo2axi_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo2axi_sync
//   Directed plus randomized bench for fifo2axi_sync. Packets are described as
//   a header plus a list of data words. Expected beats are derived by pairing
//   the words. A FWFT FIFO is modelled with a queue.
// -----------------------------------------------------------------------------
module tb_fifo2axi_sync;

  localparam int MEM_W = 202;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [MEM_W-1:0]  din;
  logic              din_valid;
  logic              din_rd;
  logic [255:0]      m_tdata;
  logic [31:0]       m_tstrb;
  logic [127:0]      m_tuser;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic              pkt_done;
  logic              err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int stall_pops = 0;
  int exp_err = 0;

  logic [MEM_W-1:0] fifo_q[$];
  beat_t            exp_q[$];
  beat_t            prev;
  logic             held = 1'b0;

  fifo2axi_sync dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_rd    (din_rd),
    .m_tdata   (m_tdata),
    .m_tstrb   (m_tstrb),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .pkt_done  (pkt_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [MEM_W-1:0] mk_word(input logic [127:0] pl, input logic [15:0] st,
                                               input logic eop, input logic sop);
    logic [MEM_W-1:0] w;
    w = '0;
    w[127:0]   = pl;
    w[143:128] = st;
    w[144]     = eop;
    w[145]     = sop;
    w[177:146] = $urandom;          // ignored bits carry junk
    w[201:178] = 24'($urandom);
    return w;
  endfunction

  // Queue a packet and the beats it must produce.
  task automatic send_pkt(input logic [127:0] user, input int n,
                          input logic [15:0] last_strb, input bit seq);
    logic [127:0] pl[$];
    logic [15:0]  st[$];
    beat_t        b;
    fifo_q.push_back(mk_word(user, 16'hFFFF, 1'b0, 1'b1));
    for (int i = 0; i < n; i++) begin
      pl.push_back(seq ? 128'(i + 1) : {$urandom, $urandom, $urandom, $urandom});
      st.push_back((i == n - 1) ? last_strb : 16'hFFFF);
      fifo_q.push_back(mk_word(pl[i], st[i], i == n - 1, 1'b0));
    end
    for (int i = 0; i < n; i += 2) begin
      b.user = user;
      if (i + 1 < n) begin
        b.data = {pl[i+1], pl[i]};
        b.strb = {st[i+1], st[i]};
        b.last = (i + 1 == n - 1);
      end else begin
        b.data = {128'b0, pl[i]};
        b.strb = {16'b0, st[i]};
        b.last = 1'b1;
      end
      exp_q.push_back(b);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, pop at posedge.
  task automatic cycle(input int vp, input int rp);
    logic  popped;
    beat_t e;
    @(negedge clk);
    if (fifo_q.size() > 0 && $urandom_range(99) < vp) begin
      din_valid = 1'b1;
      din       = fifo_q[0];
    end else begin
      din_valid = 1'b0;
      din       = '0;
    end
    m_tready = ($urandom_range(99) < rp);
    #1;
    if (held) begin
      check("hold_tvalid", 256'(m_tvalid), 256'(1'b1));
      check("hold_tdata",  m_tdata, prev.data);
      check("hold_tstrb",  256'(m_tstrb), 256'(prev.strb));
      check("hold_tuser",  256'(m_tuser), 256'(prev.user));
      check("hold_tlast",  256'(m_tlast), 256'(prev.last));
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 256'(m_tvalid), 256'(1'b0));
      end else begin
        e = exp_q.pop_front();
        check("beat_tdata", m_tdata, e.data);
        check("beat_tstrb", 256'(m_tstrb), 256'(e.strb));
        check("beat_tuser", 256'(m_tuser), 256'(e.user));
        check("beat_tlast", 256'(m_tlast), 256'(e.last));
        check("pkt_done",   256'(pkt_done), 256'(e.last));
      end
    end else begin
      check("pkt_done_idle", 256'(pkt_done), 256'(1'b0));
    end
    if (err) err_seen++;
    popped = din_rd && din_valid;
    if (popped && m_tvalid && !m_tready) stall_pops++;
    held      = m_tvalid && !m_tready;
    prev.data = m_tdata;
    prev.strb = m_tstrb;
    prev.user = m_tuser;
    prev.last = m_tlast;
    @(posedge clk);
    if (popped) void'(fifo_q.pop_front());
  endtask

  task automatic drain(input int vp, input int rp, input int budget);
    int k = 0;
    while ((exp_q.size() > 0 || fifo_q.size() > 0) && k < budget) begin
      cycle(vp, rp);
      k++;
    end
    check("drain_beats_left", 256'(exp_q.size()), 256'(0));
    check("drain_words_left", 256'(fifo_q.size()), 256'(0));
    repeat (3) cycle(100, 100);
  endtask

  initial begin
    reset     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    m_tready  = 1'b0;
    #1;
    check("rst_tvalid", 256'(m_tvalid), 256'(1'b0));
    check("rst_tlast",  256'(m_tlast),  256'(1'b0));
    check("rst_tdata",  m_tdata, 256'(0));
    check("rst_tstrb",  256'(m_tstrb), 256'(0));
    check("rst_tuser",  256'(m_tuser), 256'(0));
    check("rst_pkt_done", 256'(pkt_done), 256'(1'b0));
    check("rst_err",    256'(err), 256'(1'b0));
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 1: six sequential words, always ready.
    send_pkt(128'hAF000001, 6, 16'hFFFF, 1'b1);
    drain(100, 100, 100);

    // 2: odd word count gives a half beat with a partial strobe.
    send_pkt(128'hAF000002, 3, 16'h0FFF, 1'b0);
    drain(100, 100, 100);

    // 3: stall after the first beat. The held beat must stay stable and at most one LO word may pop.
    send_pkt(128'hAF000001, 6, 16'hFFFF, 1'b1);
    for (int k = 0; k < 30 && !m_tvalid; k++) cycle(100, 0);
    check("stall_reach_valid", 256'(m_tvalid), 256'(1'b1));
    stall_pops = 0;
    repeat (10) cycle(100, 0);
    check("stall_pops_le1", 256'(stall_pops <= 1), 256'(1'b1));
    drain(100, 100, 100);

    // 4: two packets back to back.
    send_pkt(128'hAF00AF00, 6, 16'hFFFF, 1'b0);
    send_pkt(128'hEA00EA00, 5, 16'h00FF, 1'b0);
    drain(100, 100, 200);

    // 5: reset while a beat is stalled and the HI word is still pending.
    send_pkt(128'hAF000005, 4, 16'hFFFF, 1'b0);
    for (int k = 0; k < 30 && fifo_q.size() > 1; k++) cycle(100, 0);
    check("hi_pending_words", 256'(fifo_q.size()), 256'(1));
    check("hi_pending_tvalid", 256'(m_tvalid), 256'(1'b1));
    @(negedge clk);
    din_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_tvalid", 256'(m_tvalid), 256'(1'b0));
    check("midrst_tdata",  m_tdata, 256'(0));
    check("midrst_tlast",  256'(m_tlast), 256'(1'b0));
    fifo_q.delete();
    exp_q.delete();
    held = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("postrst_tvalid", 256'(m_tvalid), 256'(1'b0));
    send_pkt(128'hAF000006, 5, 16'h0003, 1'b0);
    drain(100, 100, 100);

`ifdef FIFO2AXI_ERR_CHECK_EN
    // 6: stray non-sop header, then a sop word at the second data position.
    fifo_q.push_back(mk_word(128'h1234, 16'hFFFF, 1'b0, 1'b0));
    fifo_q.push_back(mk_word(128'hDEAD0001, 16'hFFFF, 1'b0, 1'b1));
    fifo_q.push_back(mk_word(128'h5555, 16'hFFFF, 1'b0, 1'b0));
    send_pkt(128'hBEEF0001, 4, 16'hFFFF, 1'b0);
    drain(100, 100, 100);
    exp_err = 2;
`endif

    // Random traffic with random FIFO gaps and backpressure.
    for (int p = 0; p < 12; p++) begin
      send_pkt({$urandom, $urandom, $urandom, $urandom}, 1 + int'($urandom_range(8)),
               16'($urandom), 1'b0);
      if ($urandom_range(1) == 1) drain(60, 70, 400);
    end
    drain(60, 70, 2000);

    check("err_pulses", 256'(err_seen), 256'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
